// File: rtl/common_pkg.sv
// Shared types for the MIPS memory subsystem: scalar aliases, FSM state and default RAM depth.
package common;
    typedef logic        u1;
    typedef logic [31:0] u32;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } memsys_state_t;

    localparam int MEMSYS_DEPTH_DEFAULT = 256;
endpackage

// File: rtl/mips_memsys_ram.sv
// DEPTH x 32 word RAM: combinational read, one synchronous write port.
// Latency: read 0 cycles, write lands at the clock edge. No backpressure.
module mips_memsys_ram
    import common::*;
#(
    parameter int DEPTH = MEMSYS_DEPTH_DEFAULT,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    u32 mem_q [DEPTH];

    // Contents are deliberately not reset: a mid-boot reset must keep loaded words.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/mips_memsys.sv
// Unified I/D memory for the multicycle MIPS core: RAM, IR, MDR and a stream boot loader.
// Latency: IR/MDR valid after the access edge. Boot stream always ready in BOOT, never in RUN.
// Optional sticky misalignment flag built only with MEMSYS_ALIGN_CHECK_EN.
module mips_memsys
    import common::*;
#(
    parameter int DEPTH = MEMSYS_DEPTH_DEFAULT,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    input  logic        iord,
    input  logic        memwrite,
    input  logic        irwrite,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        core_reset_n,
    output logic [31:0] instr,
    output logic [31:0] readdata,
    output logic        err_misalign
);
    memsys_state_t state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    u32            ir_q, ir_d;
    u32            mdr_q, mdr_d;

    u32            addr;
    logic [AW-1:0] idx;
    u1             ram_we;
    logic [AW-1:0] ram_waddr;
    u32            ram_wdata;
    u32            ram_rdata;
    u1             unused_addr_bits;

    assign addr             = iord ? aluout : pc;
    assign idx              = addr[AW+1:2];
    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

    mips_memsys_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (idx),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ir_d      = ir_q;
        mdr_d     = mdr_q;
        ram_we    = 1'b0;
        ram_waddr = idx;
        ram_wdata = writedata;
        ld_ready  = 1'b0;
        case (state_q)
            BOOT: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    ram_we    = 1'b1;
                    ram_waddr = cnt_q;
                    ram_wdata = ld_data;
                    cnt_d     = cnt_q + AW'(1);
                    // Running off the end of RAM also ends the boot.
                    if (ld_last || cnt_q == AW'(DEPTH - 1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                mdr_d = ram_rdata;
                if (irwrite) begin
                    ir_d = ram_rdata;
                end
                if (memwrite) begin
                    ram_we = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            cnt_q   <= '0;
            ir_q    <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
        end
    end

    assign core_reset_n = (state_q == RUN);
    assign instr        = ir_q;
    assign readdata     = mdr_q;

`ifdef MEMSYS_ALIGN_CHECK_EN
    u1 err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == RUN && (irwrite | memwrite | iord) && addr[1:0] != 2'b00) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_misalign = err_q;
`else
    assign err_misalign = 1'b0;
`endif
endmodule

// File: tb/tb_mips_memsys.sv
// Directed bench for mips_memsys: boot, fetch, load/store, wrap, misalign and reset-mid-boot.
module tb_mips_memsys;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, aluout, writedata, ld_data;
    logic        iord, memwrite, irwrite, ld_valid, ld_last;
    logic        ld_ready, core_reset_n, err_misalign;
    logic [31:0] instr, readdata;

    int total = 0;
    int bad   = 0;

`ifdef MEMSYS_ALIGN_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    mips_memsys #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .aluout       (aluout),
        .writedata    (writedata),
        .iord         (iord),
        .memwrite     (memwrite),
        .irwrite      (irwrite),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
        .ld_ready     (ld_ready),
        .core_reset_n (core_reset_n),
        .instr        (instr),
        .readdata     (readdata),
        .err_misalign (err_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        iord   = 1'b1;
        aluout = a;
        tick();
        chk(tag, readdata, exp);
    endtask

    initial begin
        reset = 1'b0;
        pc = '0; aluout = '0; writedata = '0; ld_data = '0;
        iord = 0; memwrite = 0; irwrite = 0; ld_valid = 0; ld_last = 0;
        tick();
        tick();
        chk("rst_instr", instr, 32'h0);
        chk("rst_mdr", readdata, 32'h0);
        chk("rst_core_n", {31'b0, core_reset_n}, 32'h0);
        chk("rst_ld_ready", {31'b0, ld_ready}, 32'h1);
        chk("rst_err", {31'b0, err_misalign}, 32'h0);
        reset = 1'b1;

        // Boot three words, last on the third.
        ld_valid = 1; ld_data = 32'h11; ld_last = 0;
        chk("boot0_rdy", {31'b0, ld_ready}, 32'h1);
        tick();
        chk("boot0_core_n", {31'b0, core_reset_n}, 32'h0);
        ld_data = 32'h22;
        chk("boot1_rdy", {31'b0, ld_ready}, 32'h1);
        tick();
        chk("boot1_core_n", {31'b0, core_reset_n}, 32'h0);
        ld_data = 32'h33; ld_last = 1;
        chk("boot2_rdy", {31'b0, ld_ready}, 32'h1);
        tick();
        ld_valid = 0; ld_last = 0;
        chk("run_core_n", {31'b0, core_reset_n}, 32'h1);
        chk("run_ld_ready", {31'b0, ld_ready}, 32'h0);

        rd(32'h0, 32'h11, "ram0");
        rd(32'h4, 32'h22, "ram1");
        rd(32'h8, 32'h33, "ram2");

        // Fetch via pc, then hold IR with irwrite low.
        iord = 0; pc = 32'h8; irwrite = 1;
        tick();
        chk("fetch_pc8", instr, 32'h33);
        irwrite = 0; pc = 32'h0;
        tick();
        chk("ir_hold", instr, 32'h33);
        chk("mdr_pc0", readdata, 32'h11);

        // Store with read-before-write, then read back.
        iord = 1; aluout = 32'h4; writedata = 32'hDEADBEEF; memwrite = 1;
        tick();
        chk("store_old", readdata, 32'h22);
        memwrite = 0;
        tick();
        chk("store_new", readdata, 32'hDEADBEEF);
        rd(DEPTH * 4 + 4, 32'hDEADBEEF, "wrap");

        // Store word 3, then show ld_valid is ignored in RUN.
        aluout = 32'hC; writedata = 32'h44; memwrite = 1;
        tick();
        memwrite = 0;
        ld_valid = 1; ld_data = 32'h99; ld_last = 1;
        chk("run_ignores_ld", {31'b0, ld_ready}, 32'h0);
        tick();
        ld_valid = 0; ld_last = 0;
        rd(32'hC, 32'h44, "ram3");
        chk("run_stays", {31'b0, core_reset_n}, 32'h1);

        // Misaligned fetch.
        chk("err_pre", {31'b0, err_misalign}, 32'h0);
        iord = 0; pc = 32'h6; irwrite = 1;
        tick();
        chk("fetch_misalign", instr, 32'hDEADBEEF);
        chk("err_set", {31'b0, err_misalign}, {31'b0, ERR_EXP});
        irwrite = 0; pc = 32'h0;
        tick();
        chk("err_sticky", {31'b0, err_misalign}, {31'b0, ERR_EXP});

        // Reset mid-run returns to BOOT with cleared registers.
        reset = 0;
        #1;
        chk("rr_core_n", {31'b0, core_reset_n}, 32'h0);
        chk("rr_instr", instr, 32'h0);
        chk("rr_mdr", readdata, 32'h0);
        chk("rr_err", {31'b0, err_misalign}, 32'h0);
        chk("rr_ld_ready", {31'b0, ld_ready}, 32'h1);
        tick();
        reset = 1;

        // Two boot words with stray core strobes that must be ignored.
        iord = 1; irwrite = 1; memwrite = 1; aluout = 32'hC; writedata = 32'hBAD;
        ld_valid = 1; ld_data = 32'hA1;
        tick();
        chk("boot_mdr0", readdata, 32'h0);
        chk("boot_ir0", instr, 32'h0);
        ld_data = 32'hA2;
        tick();
        iord = 0; irwrite = 0; memwrite = 0; ld_valid = 0;
        reset = 0;
        tick();
        chk("mb_core_n", {31'b0, core_reset_n}, 32'h0);
        reset = 1;
        ld_valid = 1; ld_data = 32'hB0; ld_last = 1;
        tick();
        ld_valid = 0; ld_last = 0;
        chk("reboot_core_n", {31'b0, core_reset_n}, 32'h1);
        rd(32'h0, 32'hB0, "reboot_ram0");
        rd(32'h4, 32'hA2, "reboot_ram1");
        rd(32'h8, 32'h33, "reboot_ram2");
        rd(32'hC, 32'h44, "reboot_ram3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_memsys.md
# mips_memsys

Unified instruction/data memory subsystem for the multicycle MIPS core, directly upstream of `mips`. It owns the single-ported word RAM, the instruction register (IR) and the memory data register (MDR). It also owns a boot loader that fills RAM over a valid/ready stream while holding the core in reset. The core's `pc`, `aluout`, `writedata`, `iord`, `memwrite` and `irwrite` drive this block; `instr` and `readdata` feed the core.

## Interface

Parameters:
- `DEPTH`, 256: RAM size in 32-bit words; power of two, ≥ 4. `AW = $clog2(DEPTH)` is a localparam.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `pc` in 32: byte address for fetch.
- `aluout` in 32: byte address for data access.
- `writedata` in 32: store data.
- `iord` in 1: 0 selects `pc`, 1 selects `aluout`.
- `memwrite` in 1: store strobe.
- `irwrite` in 1: IR load enable.
- `ld_valid` in 1: boot word valid.
- `ld_data` in 32: boot word.
- `ld_last` in 1: final boot word, qualified by `ld_valid`.
- `ld_ready` out 1: boot word accepted.
- `core_reset_n` out 1: active-low reset to the core.
- `instr` out 32: IR contents.
- `readdata` out 32: MDR contents.
- `err_misalign` out 1: sticky misalignment flag (see Configuration).

## Operation

- FSM states: `BOOT`, `RUN`.
- Reset: state=`BOOT`, boot counter=0, IR=0, MDR=0, `core_reset_n`=0, `err_misalign`=0. RAM contents are not cleared.
- `BOOT`:
  - `ld_ready`=1 and `core_reset_n`=0.
  - On `ld_valid`, write `mem[cnt] <= ld_data` and increment `cnt`.
  - The boot ends when the accepted word has `ld_last`=1 or `cnt==DEPTH-1`; the next state is `RUN`.
  - Core strobes are ignored: no writes; IR and MDR hold 0.
- `RUN`:
  - `ld_ready`=0; `ld_valid` is ignored.
  - `core_reset_n`=1, driven from the state register (no combinational path).
  - `RUN` persists until `reset`. There is no return to `BOOT` otherwise.
- Address: `addr = iord ? aluout : pc`; word index = `addr[AW+1:2]`. Upper bits are ignored, so addresses wrap modulo DEPTH words. `addr[1:0]` is ignored for data.
- Read: combinational from RAM at the word index.
  - MDR loads the read value on every `RUN` cycle.
  - IR loads the read value only when `irwrite`=1.
- Write: in `RUN` with `memwrite`=1, `mem[idx] <= writedata` at the edge.
- Read/write same cycle, same address: MDR and IR capture the old contents (read-before-write).
- Reset mid-boot: the counter returns to 0 and words already written remain.
- Reset mid-run: back to `BOOT`, core held, and the program must be reloaded or re-acknowledged via an `ld_last` word.

## Timing

- Boot write: word accepted at edge N, visible to reads from cycle N+1.
- `ld_last` accepted at edge N: `RUN` and `core_reset_n`=1 from cycle N+1. The first core fetch is at cycle N+1, and IR is valid after edge N+1.
- Fetch latency: `pc` presented with `irwrite` in cycle K → `instr` valid after edge K.
- Data latency: `aluout` with `iord`=1 in cycle K → `readdata` valid after edge K. The core consumes it in cycle K+1.
- Store: committed at the edge ending the `memwrite` cycle.

## Configuration

- `MEMSYS_ALIGN_CHECK_EN` defined:
  - `err_misalign` sets at the edge of any `RUN` cycle where `(irwrite | memwrite | iord)` and `addr[1:0]!=0`.
  - Sticky until `reset`.
  - The access itself still proceeds (truncated word index).
- Undefined: `err_misalign` is tied 0, with no flop or compare logic.

## Structure

- Shared package `common`: `memsys_state_t` enum {`BOOT`, `RUN`} and `MEMSYS_DEPTH_DEFAULT` = 256. Reuse the existing `u1`/`u32` typedefs.
- Sub-module `mips_memsys_ram`: DEPTH×32 array, combinational read port, one synchronous write port. The write mux between boot and core sits in the parent.
- Parent holds the FSM, boot counter, IR, MDR, address mux and misalign logic.

## Test plan

- Boot three words 0x11, 0x22, 0x33 (last on third) → `ld_ready`=1 throughout, `core_reset_n` rises the cycle after the third accept, and RAM[0..2] hold those values.
- Fetch `pc`=0x8 with `irwrite`=1 after boot → `instr`=0x33 next cycle. With `irwrite`=0, `instr` holds its prior value.
- Store `aluout`=0x4, `writedata`=0xDEADBEEF, `memwrite`=1, `iord`=1, then read the same address → MDR = old 0x22 in the store cycle, and 0xDEADBEEF on the following read.
- `aluout`=DEPTH*4+4 read → returns RAM[1] (wrap).
- Assert `reset`=0 after two boot words, release, and boot one word with `ld_last` → it is written to RAM[0]; RAM[1] retains the previous value; `core_reset_n`=0 during reset.
- With `MEMSYS_ALIGN_CHECK_EN`, fetch from `pc`=0x6 → `err_misalign`=1 and stays 1. Without the macro → it stays 0.
